// File: rtl/tc_hdd_pkg.sv
// Shared types and constants for the TC disk block-transfer controller.
package tc_hdd_pkg;

    localparam int WORD_W    = 64;
    localparam int LEN_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/tc_hdd_rd_fifo.sv
// Two-entry read-return FIFO carrying a disk word plus its end-of-block flag.
module tc_hdd_rd_fifo
    import tc_hdd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [WORD_W-1:0] head_data,
    output logic              head_last
);

    logic [WORD_W:0] slot [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= {push_last, push_data};
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign {head_last, head_data} = slot[rd_ptr];

endmodule

// File: rtl/tc_hdd_ctrl.sv
// Block-transfer controller for the TC sequential-access disk; tracks the head and issues relative seeks.
// Optional address bounds check enabled by defining TC_HDD_CTRL_BOUNDS_EN.
//
// state | meaning
// IDLE  | waiting for a command (read commands also wait for the FIFO to drain)
// SEEK  | one cycle moving the head from pos to the command address
// XFER  | one word per cycle saved or loaded, stalls on wr_valid / FIFO space
// DONE  | one-cycle completion pulse
module tc_hdd_ctrl
    import tc_hdd_pkg::*;
#(
    parameter int LEN_W     = LEN_W_DEF,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [WORD_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WORD_W-1:0] hdd_seek,
    output logic              hdd_load,
    output logic              hdd_save,
    output logic [WORD_W-1:0] hdd_in,
    input  logic [WORD_W-1:0] hdd_out
);

`ifdef TC_HDD_CTRL_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_t            state, state_nx;
    logic [WORD_W-1:0] pos;
    logic [WORD_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  cnt;
    logic              is_write;
    logic              inflight;
    logic              inflight_last;
    logic              err_q;

    logic [1:0]        fifo_count;
    logic [WORD_W-1:0] head_data;
    logic              head_last;
    logic              fifo_empty;

    logic              accept;
    logic              oob;
    logic              reject;
    logic              pop;
    logic              issue_rd;
    logic              do_save;
    logic              step;
    logic              final_word;

    assign fifo_empty = (fifo_count == 2'd0);
    assign cmd_ready  = (state == IDLE) && (cmd_write || fifo_empty);
    assign accept     = cmd_valid && cmd_ready;

    // Unbounded compare: widen by one bit so addr+len cannot wrap under the limit.
    assign oob    = ({1'b0, cmd_addr} + (WORD_W+1)'(cmd_len)) > (WORD_W+1)'(MEM_WORDS);
    assign reject = BOUNDS_EN && oob;

    assign rd_valid = !fifo_empty;
    assign pop      = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? head_data : '0;
    assign rd_last  = rd_valid && head_last;

    // Counting the same-cycle pop lets reads sustain one word per cycle.
    assign issue_rd = (state == XFER) && !is_write &&
                      ((3'(fifo_count) + 3'(inflight)) < (3'd2 + 3'(pop)));
    assign do_save    = (state == XFER) && is_write && wr_valid;
    assign step       = issue_rd || do_save;
    assign final_word = (cnt == LEN_W'(len - 1'b1));

    always_comb begin
        state_nx = state;
        hdd_seek = '0;
        hdd_load = 1'b0;
        hdd_save = 1'b0;
        hdd_in   = '0;
        wr_ready = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !reject) begin
                    if (cmd_len == '0)        state_nx = DONE;
                    else if (cmd_addr == pos) state_nx = XFER;
                    else                      state_nx = SEEK;
                end
            end
            SEEK: begin
                hdd_seek = addr - pos;
                state_nx = XFER;
            end
            XFER: begin
                if (do_save) begin
                    wr_ready = 1'b1;
                    hdd_save = 1'b1;
                    hdd_in   = wr_data;
                    hdd_seek = WORD_W'(1);
                end
                if (issue_rd) begin
                    hdd_load = 1'b1;
                    hdd_seek = WORD_W'(1);
                end
                if (step && final_word) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pos           <= '0;
            addr          <= '0;
            len           <= '0;
            cnt           <= '0;
            is_write      <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state         <= state_nx;
            err_q         <= accept && reject;
            inflight      <= issue_rd;
            inflight_last <= issue_rd && final_word;
            if (accept) begin
                is_write <= cmd_write;
                addr     <= cmd_addr;
                len      <= cmd_len;
                cnt      <= '0;
            end
            if (state == SEEK) begin
                pos <= addr;
            end else if (step) begin
                pos <= pos + WORD_W'(1);
                cnt <= cnt + LEN_W'(1);
            end
        end
    end

    tc_hdd_rd_fifo u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (hdd_out),
        .push_last (inflight_last),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (head_data),
        .head_last (head_last)
    );

    assign busy = (state != IDLE) || !fifo_empty;
    assign done = (state == DONE);
    assign err  = err_q;

endmodule
